// File: rtl/pcihellocore_input_scanner_pkg.sv
// pcihellocore_input_scanner_pkg: shared register map and widths for the input scanner.
`default_nettype none

package pcihellocore_input_scanner_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_EDGE   = 2'd2;
  localparam logic [1:0] ADDR_PERIOD = 2'd3;

  localparam int PERIOD_W  = 16;
  localparam int DBC_CNT_W = 2;

  // A programmed period of zero behaves like a period of one.
  function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] p);
    return (p == '0) ? PERIOD_W'(1) : p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pcihellocore_input_debounce.sv
// pcihellocore_input_debounce: one-bit two-flop synchroniser plus tick-driven debounce.
`default_nettype none

module pcihellocore_input_debounce
  import pcihellocore_input_scanner_pkg::*;
#(
  parameter int STABLE_TICKS = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  input  logic i_tick,
  output logic o_stable,
  output logic o_rise
);

  localparam logic [DBC_CNT_W-1:0] C_CNT_LAST = DBC_CNT_W'(STABLE_TICKS - 1);

  logic                 r_meta;
  logic                 r_sync;
  logic                 r_stable;
  logic [DBC_CNT_W-1:0] r_cnt;
  logic                 w_accept;

  assign w_accept = i_tick && (r_sync != r_stable) && (r_cnt == C_CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      if (i_tick) begin
        if (r_sync == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == C_CNT_LAST) begin
          r_stable <= r_sync;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + DBC_CNT_W'(1);
        end
      end
    end
  end

  assign o_stable = r_stable;
  // Rise is reported on the same edge that stable flips to 1.
  assign o_rise   = w_accept && r_sync;

endmodule

`default_nettype wire

// File: rtl/pcihellocore_input_scanner.sv
// pcihellocore_input_scanner: Avalon-MM debounced, edge-capturing input controller.
// Optional interrupt path and IRQ_MASK register enabled by INPUT_SCANNER_IRQ_EN.
`default_nettype none

module pcihellocore_input_scanner
  import pcihellocore_input_scanner_pkg::*;
#(
  parameter int          WIDTH          = 32,
  parameter logic [15:0] DEFAULT_PERIOD = 16'd50000,
  parameter int          STABLE_TICKS   = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port
`ifdef INPUT_SCANNER_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam logic [PERIOD_W-1:0] C_ONE = PERIOD_W'(1);

  logic                w_wr;
  logic                w_tick;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_tick_cnt;
  logic [WIDTH-1:0]    w_stable;
  logic [WIDTH-1:0]    w_rise;
  logic [WIDTH-1:0]    w_edge_clr;
  logic [WIDTH-1:0]    r_edge;
  logic [WIDTH-1:0]    w_mask;
  logic [31:0]         w_rdmux;
  logic                w_unused;

  assign w_wr     = chipselect && !write_n;
  assign w_tick   = (r_tick_cnt == (eff_period(r_period) - C_ONE));
  assign w_unused = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period   <= DEFAULT_PERIOD;
      r_tick_cnt <= '0;
    end else if (w_wr && (address == ADDR_PERIOD)) begin
      r_period   <= writedata[PERIOD_W-1:0];
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + C_ONE;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    pcihellocore_input_debounce #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_dbc (
      .clk     (clk),
      .reset_n (reset_n),
      .i_raw   (in_port[gi]),
      .i_tick  (w_tick),
      .o_stable(w_stable[gi]),
      .o_rise  (w_rise[gi])
    );
  end

  // A new rise wins over a simultaneous write-1-to-clear.
  assign w_edge_clr = (w_wr && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge <= '0;
    end else begin
      r_edge <= (r_edge & ~w_edge_clr) | w_rise;
    end
  end

`ifdef INPUT_SCANNER_IRQ_EN
  logic [WIDTH-1:0] r_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
    end else if (w_wr && (address == ADDR_MASK)) begin
      r_mask <= writedata[WIDTH-1:0];
    end
  end

  assign w_mask = r_mask;
  assign irq    = |(r_edge & r_mask);
`else
  assign w_mask = '0;
`endif

  always_comb begin
    w_rdmux = '0;
    case (address)
      ADDR_DATA:   w_rdmux[WIDTH-1:0]    = w_stable;
      ADDR_MASK:   w_rdmux[WIDTH-1:0]    = w_mask;
      ADDR_EDGE:   w_rdmux[WIDTH-1:0]    = r_edge;
      ADDR_PERIOD: w_rdmux[PERIOD_W-1:0] = r_period;
      default:     w_rdmux               = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= w_rdmux;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pcihellocore_input_scanner.sv
// tb_pcihellocore_input_scanner: directed plus randomized bench with a behavioural reference model.
`default_nettype none

module tb_pcihellocore_input_scanner;

  localparam int W  = 32;
  localparam int ST = 3;

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b1;
  logic [1:0]    address    = '0;
  logic          chipselect = 1'b0;
  logic          write_n    = 1'b1;
  logic [31:0]   writedata  = '0;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port    = '0;
`ifdef INPUT_SCANNER_IRQ_EN
  logic          irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  pcihellocore_input_scanner #(
    .WIDTH         (W),
    .DEFAULT_PERIOD(16'd50000),
    .STABLE_TICKS  (ST)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port)
`ifdef INPUT_SCANNER_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tick = every eff-th cycle since the last anchor (reset or PERIOD write);
  // a bit is accepted once ST consecutive tick samples disagree with the debounced level.
  logic [W-1:0] m_sync1  = '0;
  logic [W-1:0] m_sync2  = '0;
  logic [W-1:0] m_stable = '0;
  logic [W-1:0] m_edge   = '0;
  logic [W-1:0] m_mask   = '0;
  logic [15:0]  m_period = 16'd50000;
  logic [31:0]  m_rd     = '0;
  int           m_since  = 0;
  int           m_run[W];

  task automatic model_reset();
    m_sync1  = '0;
    m_sync2  = '0;
    m_stable = '0;
    m_edge   = '0;
    m_mask   = '0;
    m_period = 16'd50000;
    m_rd     = '0;
    m_since  = 0;
    for (int b = 0; b < W; b++) m_run[b] = 0;
  endtask

  task automatic model_step();
    int           eff;
    bit           tick;
    bit           wr;
    logic [W-1:0] rises;
    logic [W-1:0] clr;
    eff  = (m_period == 16'd0) ? 1 : int'(m_period);
    tick = ((m_since % eff) == (eff - 1));
    wr   = chipselect && !write_n;
    case (address)
      2'd0:    m_rd = 32'(m_stable);
      2'd1:    m_rd = 32'(m_mask);
      2'd2:    m_rd = 32'(m_edge);
      default: m_rd = {16'h0, m_period};
    endcase
    rises = '0;
    if (tick) begin
      for (int b = 0; b < W; b++) begin
        if (m_sync2[b] !== m_stable[b]) begin
          m_run[b]++;
          if (m_run[b] >= ST) begin
            m_stable[b] = m_sync2[b];
            rises[b]    = m_sync2[b];
            m_run[b]    = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
    end
    m_sync2 = m_sync1;
    m_sync1 = in_port;
    clr     = (wr && address == 2'd2) ? writedata[W-1:0] : '0;
    m_edge  = (m_edge & ~clr) | rises;
`ifdef INPUT_SCANNER_IRQ_EN
    if (wr && address == 2'd1) m_mask = writedata[W-1:0];
`endif
    if (wr && address == 2'd3) begin
      m_period = writedata[15:0];
      m_since  = 0;
    end else begin
      m_since++;
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check_eq("readdata", readdata, m_rd);
`ifdef INPUT_SCANNER_IRQ_EN
      check_eq("irq", 32'(irq), 32'(|(m_edge & m_mask)));
`endif
    end
  end

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); #1;
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_expect(input string tag, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clk); #1 address = a;
    @(negedge clk);
    check_eq(tag, readdata, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a new level just before edge e0 and check DATA is still old at e4, new from e5.
  task automatic accept_timing(input string tag, input logic [W-1:0] val, input logic [31:0] old_v);
    @(negedge clk); #1 in_port = val; address = 2'd0;
    repeat (4) @(negedge clk);
    @(negedge clk); check_eq({tag, "_e4"}, readdata, old_v);
    @(negedge clk); check_eq({tag, "_e5"}, readdata, 32'(val));
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #1 chk_on  = 1'b1;
    idle(3);
    #1 reset_n = 1'b1;

    rd_expect("rst_data",   2'd0, 32'd0);
    rd_expect("rst_mask",   2'd1, 32'd0);
    rd_expect("rst_edge",   2'd2, 32'd0);
    rd_expect("rst_period", 2'd3, 32'd50000);

    wr_reg(2'd3, 32'd1);
    accept_timing("accept", 'h1, 32'h0);
    rd_expect("accept_edge", 2'd2, 32'h1);

    wr_reg(2'd2, 32'hFFFF_FFFF);
    wr_reg(2'd3, 32'd4);
    @(negedge clk); #1 in_port = 'h9;
    idle(6);
    #1 in_port = 'h1;
    idle(20);
    rd_expect("glitch_data", 2'd0, 32'h1);
    rd_expect("glitch_edge", 2'd2, 32'h0);

    wr_reg(2'd3, 32'd1);
    #1 in_port = '0;   idle(10);
    #1 in_port = 'h1;  idle(10);
    #1 in_port = '0;   idle(10);
    rd_expect("race_pre", 2'd2, 32'h1);
    @(negedge clk); #1 in_port = 'h5;
    repeat (4) @(negedge clk);
    #1 address = 2'd2; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h1;
    @(negedge clk); #1 chipselect = 1'b0; write_n = 1'b1;
    rd_expect("race_setwins", 2'd2, 32'h5);
    wr_reg(2'd2, 32'h5);
    rd_expect("race_clr", 2'd2, 32'h0);

`ifdef INPUT_SCANNER_IRQ_EN
    wr_reg(2'd1, 32'h4);
    rd_expect("mask_rb", 2'd1, 32'h4);
    #1 in_port = '0;  idle(10);
    wr_reg(2'd2, 32'hFFFF_FFFF);
    #1 in_port = 'h1; idle(10);
    check_eq("irq_bit0", 32'(irq), 32'd0);
    #1 in_port = 'h5; idle(10);
    check_eq("irq_bit2", 32'(irq), 32'd1);
    wr_reg(2'd2, 32'h4);
    check_eq("irq_clr", 32'(irq), 32'd0);
`else
    wr_reg(2'd1, 32'hFFFF_FFFF);
    rd_expect("mask_absent", 2'd1, 32'h0);
`endif

    wr_reg(2'd3, 32'd0);
    #1 in_port = '0; idle(12);
    accept_timing("period0", 'h2, 32'h0);
    rd_expect("period0_rb", 2'd3, 32'h0);

    wr_reg(2'd3, 32'd5);
    idle(3);
    #1 in_port = 'h10;
    idle(2);
    wr_reg(2'd3, 32'd5);
    idle(30);
    rd_expect("midwrite_data", 2'd0, 32'h10);
    rd_expect("midwrite_rb",   2'd3, 32'd5);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      if (c == 2000) reset_n = 1'b0;
      if (c == 2003) reset_n = 1'b1;
      address    = 2'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 1) == 1);
      write_n    = ($urandom_range(0, 5) != 0);
      writedata  = (address == 2'd3) ? 32'($urandom_range(0, 6)) : $urandom;
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 1) in_port = W'($urandom);
        else                           in_port = in_port ^ (W'(1) << $urandom_range(0, W-1));
      end
    end
    @(negedge clk); #1 chipselect = 1'b0; write_n = 1'b1;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
